// File: rtl/vga_display_timing_if.sv
// Raster timing bundle shared between the VGA timing generator and the
// pixel-colour stage / board pins. The master side drives every signal.
interface vga_display_timing_if;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        pix_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output hCount,
        output vCount,
        output hSync,
        output vSync,
        output bright,
        output pix_tick,
        output frame_tick,
        output frame_count
    );

    modport slave (
        input hCount,
        input vCount,
        input hSync,
        input vSync,
        input bright,
        input pix_tick,
        input frame_tick,
        input frame_count
    );
endinterface

// File: rtl/vga_display_timing.sv
// VGA raster timing generator: a clock divider produces the pixel enable,
// horizontal/vertical counters scan the frame, and sync, active-video and
// tick qualifiers are registered alongside the counters so every output
// describes the same (hCount, vCount) position in the same cycle.
// Optional feature macro: VGA_FRAME_COUNT_EN builds the 16-bit completed
// frame counter; without it frame_count is tied to zero.
module vga_display_timing #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_display_timing_if.master  vga
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_L      = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_L      = 10'(V_SYNC);
    localparam logic [9:0]       H_ACT_START_L = 10'(H_ACT_START);
    localparam logic [9:0]       H_ACT_END_L   = 10'(H_ACT_END);
    localparam logic [9:0]       V_ACT_START_L = 10'(V_ACT_START);
    localparam logic [9:0]       V_ACT_END_L   = 10'(V_ACT_END);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hCount;
    logic [9:0]       r_vCount;
    logic             r_hSync;
    logic             r_vSync;
    logic             r_bright;
    logic             r_pixTick;
    logic             r_frameTick;

    logic             w_pixEn;
    logic [9:0]       w_hNext;
    logic [9:0]       w_vNext;
    logic             w_frameWrap;

    assign w_pixEn = (r_div == DIV_LAST);

    // Next counter position and whether this advance closes a frame
    always_comb begin
        w_hNext     = r_hCount;
        w_vNext     = r_vCount;
        w_frameWrap = 1'b0;
        if (w_pixEn) begin
            if (r_hCount == H_LAST) begin
                w_hNext = 10'd0;
                if (r_vCount == V_LAST) begin
                    w_vNext     = 10'd0;
                    w_frameWrap = 1'b1;
                end else begin
                    w_vNext = r_vCount + 10'd1;
                end
            end else begin
                w_hNext = r_hCount + 10'd1;
            end
        end
    end

    // Divider, counters and qualifiers all register from the next position together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_hCount    <= 10'd0;
            r_vCount    <= 10'd0;
            r_hSync     <= 1'b0;
            r_vSync     <= 1'b0;
            r_bright    <= 1'b0;
            r_pixTick   <= 1'b0;
            r_frameTick <= 1'b0;
        end else begin
            r_div       <= w_pixEn ? '0 : r_div + 1'b1;
            r_hCount    <= w_hNext;
            r_vCount    <= w_vNext;
            r_hSync     <= ~(w_hNext < H_SYNC_L);
            r_vSync     <= ~(w_vNext < V_SYNC_L);
            r_bright    <= (w_hNext >= H_ACT_START_L) && (w_hNext < H_ACT_END_L) &&
                           (w_vNext >= V_ACT_START_L) && (w_vNext < V_ACT_END_L);
            r_pixTick   <= w_pixEn;
            r_frameTick <= w_frameWrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frameCount;

    // Completed-frame counter steps on the same edge that raises frame_tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frameCount <= 16'd0;
        end else if (w_frameWrap) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    assign vga.frame_count = r_frameCount;
`else
    assign vga.frame_count = 16'd0;
`endif

    assign vga.hCount     = r_hCount;
    assign vga.vCount     = r_vCount;
    assign vga.hSync      = r_hSync;
    assign vga.vSync      = r_vSync;
    assign vga.bright     = r_bright;
    assign vga.pix_tick   = r_pixTick;
    assign vga.frame_tick = r_frameTick;

endmodule

// File: tb/tb_vga_display_timing.sv
// Testbench for vga_display_timing using a reduced raster so several full
// frames fit in a short run. Expected outputs come from the number of clock
// edges since reset release: pixel index = edges / CLK_DIV, and the raster
// position, syncs, active window and ticks follow arithmetically from it.
// Frame-counter expectations follow the VGA_FRAME_COUNT_EN macro.
module tb_vga_display_timing;

    localparam int unsigned CLK_DIV     = 3;
    localparam int unsigned H_TOTAL     = 20;
    localparam int unsigned H_SYNC      = 3;
    localparam int unsigned H_ACT_START = 5;
    localparam int unsigned H_ACT_END   = 17;
    localparam int unsigned V_TOTAL     = 10;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_ACT_START = 3;
    localparam int unsigned V_ACT_END   = 8;
    localparam int unsigned FRAME_PIX   = H_TOTAL * V_TOTAL;
    localparam int unsigned ACTIVE_PIX  = (H_ACT_END - H_ACT_START) * (V_ACT_END - V_ACT_START);

    logic clk = 1'b0;
    logic reset_n;
    logic compareOn = 1'b0;

    int errors = 0;
    int checks = 0;
    int unsigned edgeCount = 0;
    int unsigned brightCnt = 0;

    int unsigned mK, mP, mH, mV;
    logic mPix, mFrame, mHs, mVs, mBright;
    logic [15:0] mFc;

    vga_display_timing_if vgaIf ();

    vga_display_timing #(
        .CLK_DIV    (CLK_DIV),
        .H_TOTAL    (H_TOTAL),
        .H_SYNC     (H_SYNC),
        .H_ACT_START(H_ACT_START),
        .H_ACT_END  (H_ACT_END),
        .V_TOTAL    (V_TOTAL),
        .V_SYNC     (V_SYNC),
        .V_ACT_START(V_ACT_START),
        .V_ACT_END  (V_ACT_END)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .vga    (vgaIf)
    );

    // 10 ns clock; posedges at 5, 15, ... and negedges at 10, 20, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Clock edges seen with reset released; cleared the instant reset asserts
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edgeCount = 0;
        else edgeCount = edgeCount + 1;
    end

    // Reference model plus per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (compareOn) begin
            mK      = edgeCount;
            mP      = mK / CLK_DIV;
            mH      = mP % H_TOTAL;
            mV      = (mP / H_TOTAL) % V_TOTAL;
            mPix    = (mK != 0) && (mK % CLK_DIV == 0);
            mFrame  = mPix && (mP % FRAME_PIX == 0);
            mHs     = !(mH < H_SYNC);
            mVs     = !(mV < V_SYNC);
            mBright = (mH >= H_ACT_START) && (mH < H_ACT_END) &&
                      (mV >= V_ACT_START) && (mV < V_ACT_END);
`ifdef VGA_FRAME_COUNT_EN
            mFc     = 16'((mP / FRAME_PIX) % 65536);
`else
            mFc     = 16'd0;
`endif
            checkOutput("hCount",      32'(vgaIf.hCount),      32'(mH));
            checkOutput("vCount",      32'(vgaIf.vCount),      32'(mV));
            checkOutput("hSync",       32'(vgaIf.hSync),       32'(mHs));
            checkOutput("vSync",       32'(vgaIf.vSync),       32'(mVs));
            checkOutput("bright",      32'(vgaIf.bright),      32'(mBright));
            checkOutput("pix_tick",    32'(vgaIf.pix_tick),    32'(mPix));
            checkOutput("frame_tick",  32'(vgaIf.frame_tick),  32'(mFrame));
            checkOutput("frame_count", 32'(vgaIf.frame_count), 32'(mFc));

            if (!reset_n) begin
                brightCnt = 0;
            end else if (vgaIf.frame_tick) begin
                checkOutput("brightPerFrame", 32'(brightCnt), 32'(ACTIVE_PIX));
                brightCnt = 0;
            end else if (vgaIf.pix_tick && vgaIf.bright) begin
                brightCnt = brightCnt + 1;
            end
        end
    end

    // Wait until the given number of edges since release, then sample 1 ns later
    task automatic gotoEdge(input int unsigned target);
        int guard = 0;
        while (edgeCount < target && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (edgeCount != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL gotoEdge: got %0d, expected %0d", edgeCount, target);
        end
    endtask

    // Free-run a while, then optionally pulse reset between clock edges
    task automatic applyStimulus(input int unsigned runCycles, input bit doReset);
        int unsigned holdCycles;
        repeat (runCycles) @(posedge clk);
        if (doReset) begin
            #($urandom_range(1, 4));
            reset_n = 1'b0;
            #1;
            checkOutput("asyncReset.hCount",     32'(vgaIf.hCount),      32'd0);
            checkOutput("asyncReset.vCount",     32'(vgaIf.vCount),      32'd0);
            checkOutput("asyncReset.syncs",      32'({vgaIf.hSync, vgaIf.vSync}), 32'd0);
            checkOutput("asyncReset.ticks",      32'({vgaIf.bright, vgaIf.pix_tick, vgaIf.frame_tick}), 32'd0);
            checkOutput("asyncReset.frameCount", 32'(vgaIf.frame_count), 32'd0);
            holdCycles = $urandom_range(1, 3);
            repeat (holdCycles) @(negedge clk);
            #2;
            reset_n = 1'b1;
        end
    endtask

    // Directed literal checks after the first release, then randomized reset pulses
    initial begin
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #2;
        compareOn = 1'b1;
        checkOutput("reset.hSync", 32'(vgaIf.hSync), 32'd0);
        checkOutput("reset.vSync", 32'(vgaIf.vSync), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;

        gotoEdge(2);
        checkOutput("edge2.hCount", 32'(vgaIf.hCount), 32'd0);
        gotoEdge(3);
        checkOutput("edge3.hCount", 32'(vgaIf.hCount), 32'd1);
        checkOutput("edge3.pix_tick", 32'(vgaIf.pix_tick), 32'd1);
        checkOutput("edge3.hSync", 32'(vgaIf.hSync), 32'd0);
        gotoEdge(4);
        checkOutput("edge4.pix_tick", 32'(vgaIf.pix_tick), 32'd0);
        gotoEdge(6);
        checkOutput("edge6.hCount", 32'(vgaIf.hCount), 32'd2);
        gotoEdge(9);
        checkOutput("edge9.hSync", 32'(vgaIf.hSync), 32'd1);
        gotoEdge(57);
        checkOutput("lineEnd.hv", 32'({vgaIf.hCount, vgaIf.vCount}), {12'd0, 10'd19, 10'd0});
        gotoEdge(60);
        checkOutput("lineWrap.hv", 32'({vgaIf.hCount, vgaIf.vCount}), {12'd0, 10'd0, 10'd1});
        checkOutput("line1.vSync", 32'(vgaIf.vSync), 32'd0);
        gotoEdge(120);
        checkOutput("line2.vSync", 32'(vgaIf.vSync), 32'd1);
        gotoEdge(195);
        checkOutput("activeRise.bright", 32'(vgaIf.bright), 32'd1);
        gotoEdge(231);
        checkOutput("activeFall.bright", 32'(vgaIf.bright), 32'd0);
        gotoEdge(600);
        checkOutput("frame1.tick", 32'(vgaIf.frame_tick), 32'd1);
        checkOutput("frame1.hv", 32'({vgaIf.hCount, vgaIf.vCount}), 32'd0);
`ifdef VGA_FRAME_COUNT_EN
        checkOutput("frame1.count", 32'(vgaIf.frame_count), 32'd1);
`else
        checkOutput("frame1.count", 32'(vgaIf.frame_count), 32'd0);
`endif
        gotoEdge(601);
        checkOutput("frame1.tickDrop", 32'(vgaIf.frame_tick), 32'd0);
        gotoEdge(1200);
        checkOutput("frame2.tick", 32'(vgaIf.frame_tick), 32'd1);
`ifdef VGA_FRAME_COUNT_EN
        checkOutput("frame2.count", 32'(vgaIf.frame_count), 32'd2);
`else
        checkOutput("frame2.count", 32'(vgaIf.frame_count), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom_range(20, 1500), 1'b1);
        end
        applyStimulus(1900, 1'b0);

        compareOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
